// File: rtl/mul8_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mul8_sequencer_pkg
// Shared ALU constants for the sequential 8x8 multiplier:
//   - state_t      : controller state encoding (IDLE, S0..S3, DONE)
//   - SH_S0..SH_S3 : left shift applied to each nibble partial product
//   - place_partial: widens an 8-bit partial product to 16 bits and shifts it
// ---------------------------------------------------------------------------
package mul8_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Nibble weights: lo*lo, hi*lo, lo*hi, hi*hi
  localparam logic [3:0] SH_S0 = 4'd0;
  localparam logic [3:0] SH_S1 = 4'd4;
  localparam logic [3:0] SH_S2 = 4'd4;
  localparam logic [3:0] SH_S3 = 4'd8;

  // Largest shifted partial product is 0xE1 << 8 = 0xE100, so 16 bits is enough.
  function automatic logic [15:0] place_partial(input logic [7:0] pp,
                                                input logic [3:0] sh);
    return {8'h00, pp} << sh;
  endfunction

endpackage

// File: rtl/mul8_sequencer_mult4.sv
// ---------------------------------------------------------------------------
// four_bit_Multiplier
// Combinational unsigned 4x4 array multiplier.
// Ports:
//   x [3:0] in  : first operand
//   y [3:0] in  : second operand
//   p [7:0] out : x * y
// ---------------------------------------------------------------------------
module four_bit_Multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [7:0] row0;
  logic [7:0] row1;
  logic [7:0] row2;
  logic [7:0] row3;

  // One shifted copy of x per set bit of y, then summed.
  assign row0 = y[0] ? {4'b0000, x}        : 8'h00;
  assign row1 = y[1] ? {3'b000, x, 1'b0}   : 8'h00;
  assign row2 = y[2] ? {2'b00, x, 2'b00}   : 8'h00;
  assign row3 = y[3] ? {1'b0, x, 3'b000}   : 8'h00;

  assign p = row0 + row1 + row2 + row3;

endmodule

// File: rtl/mul8_sequencer.sv
// ---------------------------------------------------------------------------
// mul8_sequencer
// Multi-cycle unsigned 8x8 -> 16 multiplier built around a single 4x4 array
// multiplier, time-shared over four nibble steps (S0..S3).
// Ports:
//   clk           in  : clock, rising edge
//   rst_n         in  : asynchronous active-low reset
//   start         in  : request a multiply (accepted in IDLE or DONE)
//   abort         in  : cancel an in-flight multiply (S0..S3 only)
//   a [7:0]       in  : multiplicand, captured on accepted start
//   b [7:0]       in  : multiplier, captured on accepted start
//   busy          out : high in S0..S3
//   done          out : high for the single DONE cycle
//   product [15:0]out : result register, held until the next completion
// ---------------------------------------------------------------------------
module mul8_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  import mul8_sequencer_pkg::*;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [15:0] acc;
  logic [3:0]  mul_x;
  logic [3:0]  mul_y;
  logic [7:0]  pp;
  logic [3:0]  sh;
  logic [15:0] sum;
  logic        load_ops;
  logic        acc_en;
  logic        prod_en;

  four_bit_Multiplier u_mult4 (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, nibble select and datapath enables. Abort outranks step
  // progress in S0..S3; start is only looked at in IDLE and DONE, so a start
  // arriving with abort in DONE still launches a new operation.
  always_comb begin
    state_d  = state_q;
    mul_x    = 4'h0;
    mul_y    = 4'h0;
    sh       = SH_S0;
    load_ops = 1'b0;
    acc_en   = 1'b0;
    prod_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_S0;
          load_ops = 1'b1;
        end
      end
      ST_S0: begin
        mul_x = ra[3:0];
        mul_y = rb[3:0];
        sh    = SH_S0;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_S1;
          acc_en  = 1'b1;
        end
      end
      ST_S1: begin
        mul_x = ra[7:4];
        mul_y = rb[3:0];
        sh    = SH_S1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_S2;
          acc_en  = 1'b1;
        end
      end
      ST_S2: begin
        mul_x = ra[3:0];
        mul_y = rb[7:4];
        sh    = SH_S2;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_S3;
          acc_en  = 1'b1;
        end
      end
      ST_S3: begin
        mul_x = ra[7:4];
        mul_y = rb[7:4];
        sh    = SH_S3;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          prod_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d  = ST_S0;
          load_ops = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Running sum: the final S3 sum goes straight into product, so acc never
  // needs to hold the complete result.
  assign sum = acc + place_partial(pp, sh);

  // Operand capture, accumulation and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra      <= 8'h00;
      rb      <= 8'h00;
      acc     <= 16'h0000;
      product <= 16'h0000;
    end else begin
      if (load_ops) begin
        ra  <= a;
        rb  <= b;
        acc <= 16'h0000;
      end else if (acc_en) begin
        acc <= sum;
      end
      if (prod_en) begin
        product <= sum;
      end
    end
  end

  assign busy = (state_q == ST_S0) || (state_q == ST_S1) ||
                (state_q == ST_S2) || (state_q == ST_S3);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul8_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul8_sequencer
// Self-checking bench for mul8_sequencer: a table of operand/product vectors
// run one operation at a time, then hand-written sequences for start while
// busy, back-to-back operation, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_mul8_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vector_t;

  vector_t vectors[6];

  mul8_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // 10-unit clock; inputs are driven and outputs sampled on the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic ab,
                               input logic [7:0] av, input logic [7:0] bv);
    start = s;
    abort = ab;
    a     = av;
    b     = bv;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Full single operation launched at the current falling edge: busy for
  // four sampled cycles, then one done cycle carrying the product.
  task automatic runOne(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] expected);
    applyStimulus(1'b1, 1'b0, av, bv);
    tick();
    applyStimulus(1'b0, 1'b0, av, bv);
    for (int k = 0; k < 4; k++) begin
      checkOutput("busy_during_steps", {15'b0, busy}, 16'h0001);
      checkOutput("no_done_during_steps", {15'b0, done}, 16'h0000);
      if (k < 3) tick();
    end
    tick();
    checkOutput("done_pulse", {15'b0, done}, 16'h0001);
    checkOutput("busy_low_in_done", {15'b0, busy}, 16'h0000);
    checkOutput("product", product, expected);
    tick();
    checkOutput("done_single_cycle", {15'b0, done}, 16'h0000);
    checkOutput("product_held", product, expected);
  endtask

  initial begin
    int done_count;
    checks = 0;
    errors = 0;

    vectors[0] = '{a: 8'h12, b: 8'h34, expected: 16'h03A8};
    vectors[1] = '{a: 8'hFF, b: 8'hFF, expected: 16'hFE01};
    vectors[2] = '{a: 8'h00, b: 8'hA5, expected: 16'h0000};
    vectors[3] = '{a: 8'h01, b: 8'h80, expected: 16'h0080};
    vectors[4] = '{a: 8'hAB, b: 8'hCD, expected: 16'h88EF};
    vectors[5] = '{a: 8'h0F, b: 8'hF0, expected: 16'h0E10};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("reset_busy", {15'b0, busy}, 16'h0000);
    checkOutput("reset_done", {15'b0, done}, 16'h0000);
    checkOutput("reset_product", product, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Table-driven operations
    for (int i = 0; i < 6; i++) begin
      runOne(vectors[i].a, vectors[i].b, vectors[i].expected);
    end

    // Product holds long after completion
    runOne(8'h12, 8'h34, 16'h03A8);
    repeat (10) tick();
    checkOutput("product_after_10", product, 16'h03A8);
    checkOutput("idle_busy_after_10", {15'b0, busy}, 16'h0000);

    // Start while busy (in S1) is ignored
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h34);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h0F, 8'h0F);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0F, 8'h0F);
    tick();
    tick();
    checkOutput("busy_start_done", {15'b0, done}, 16'h0001);
    checkOutput("busy_start_product", product, 16'h03A8);
    done_count = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) done_count++;
    end
    checkOutput("busy_start_no_extra_op", done_count[15:0], 16'h0000);

    // Back-to-back with start held high; abort in DONE must lose to start
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h34);
    tick();
    repeat (3) tick();
    tick();
    checkOutput("b2b_first_done", {15'b0, done}, 16'h0001);
    checkOutput("b2b_first_product", product, 16'h03A8);
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h10);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h10, 8'h10);
    checkOutput("b2b_restart_busy", {15'b0, busy}, 16'h0001);
    checkOutput("b2b_restart_no_done", {15'b0, done}, 16'h0000);
    checkOutput("b2b_product_held", product, 16'h03A8);
    repeat (4) tick();
    checkOutput("b2b_second_done", {15'b0, done}, 16'h0001);
    checkOutput("b2b_second_product", product, 16'h0100);
    tick();

    // Abort in S2: back to IDLE, no done, product untouched
    applyStimulus(1'b1, 1'b0, 8'h23, 8'h45);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h23, 8'h45);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 8'h23, 8'h45);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h23, 8'h45);
    checkOutput("abort_busy", {15'b0, busy}, 16'h0000);
    checkOutput("abort_done", {15'b0, done}, 16'h0000);
    checkOutput("abort_product", product, 16'h0100);
    done_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) done_count++;
    end
    checkOutput("abort_no_done", done_count[15:0], 16'h0000);
    runOne(8'h23, 8'h45, 16'h096F);

    // Abort while idle has no effect on a following operation
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    checkOutput("idle_abort_busy", {15'b0, busy}, 16'h0000);
    runOne(8'h07, 8'h09, 16'h003F);

    // Asynchronous reset in S1 clears everything without a clock edge
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF);
    tick();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {15'b0, busy}, 16'h0000);
    checkOutput("async_reset_done", {15'b0, done}, 16'h0000);
    checkOutput("async_reset_product", product, 16'h0000);
    tick();
    rst_n = 1'b1;
    done_count = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) done_count++;
    end
    checkOutput("post_reset_idle", done_count[15:0], 16'h0000);
    checkOutput("post_reset_product", product, 16'h0000);
    runOne(8'h12, 8'h34, 16'h03A8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul8_sequencer.md
# mul8_sequencer

- Multi-cycle controller that computes an unsigned 8×8 → 16-bit product using one 4×4 array multiplier (`four_bit_Multiplier`) time-shared over four nibble steps.
- Steps are accumulated with shifts and handshaked through start/busy/done.
- Sits between the ALU operation decoder and the result mux; gives the ALU an 8-bit multiply without a full 8×8 array.

## Interface
Parameters:
- none; operand width is fixed at 8 bits by the 4×4 datapath.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request a multiply; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous cancel of an in-flight multiply.
- `a`  in  8  multiplicand; captured when start is accepted.
- `b`  in  8  multiplier; captured when start is accepted.
- `busy`  out  1  high in states S0–S3.
- `done`  out  1  one-cycle pulse, high in state DONE.
- `product`  out  16  result register; holds its value until the next completion.

## Operation
States: IDLE, S0, S1, S2, S3, DONE.

Start acceptance:
- start=1 in IDLE or DONE: latch a→ra, b→rb, clear acc to 0, go to S0.
- start in S0–S3 is ignored. Operands and state are unaffected.

Nibble steps: the shared 4×4 multiplier is fed pp = x·y, and acc ← acc + (pp << sh) at the end of each step.
- S0: ra[3:0]·rb[3:0], sh=0.
- S1: ra[7:4]·rb[3:0], sh=4.
- S2: ra[3:0]·rb[7:4], sh=4.
- S3: ra[7:4]·rb[7:4], sh=8.

Step completion:
- Leaving S3: product ← acc + (pp<<8), go to DONE.
- DONE → S0 if start=1, otherwise → IDLE.

Width rules:
- acc and sum are 16 bits.
- Max result 0xFF·0xFF = 0xFE01, so no overflow is possible and no carry-out exists.

Abort:
- abort=1 in S0–S3 → IDLE next edge. No done pulse; product unchanged.
- abort is ignored in IDLE and DONE.
- If abort and start are both high in DONE, start wins.

Reset (rst_n low, at any time including mid-operation):
- state=IDLE; acc, ra, rb, product = 0; busy=0, done=0.
- The in-flight operation is discarded.

Multiplier inputs:
- Nibble selection is combinational from the registered state.
- In IDLE/DONE the multiplier inputs are driven to 0.

## Timing
- Start accepted at edge E0 → busy=1 from E0 until E4. done=1 for the single cycle E4–E5, with product valid at E4.
- Latency is 4 cycles from the accepting edge to product valid.
- Back-to-back: with start held high, one result every 5 cycles (DONE overlaps the next acceptance).
- busy and done are never high in the same cycle.
- done is never high two cycles in a row unless a new operation completes.
- The critical path is 4×4 array + 16-bit add within one cycle. There is no combinational path from start/a/b to any output.

## Structure
- Shared package (ALU common constants): state encodings, and step shift constants (0, 4, 4, 8).
- Sub-module: one instance of the existing `four_bit_Multiplier`, fed by the nibble-select mux.
- Everything else is local: FSM, operand registers, accumulator, product register.

## Test plan
- Basic multiply: a=0x12, b=0x34, start one cycle → busy for 4 cycles; done pulse 4 edges after acceptance with product=0x03A8; product still 0x03A8 ten cycles later.
- Max operands: a=0xFF, b=0xFF → product=0xFE01. Also a=0x00, b=0xA5 → 0x0000, and a=0x01, b=0x80 → 0x0080.
- Start while busy: start at S1 with a=0x0F, b=0x0F during a 0x12·0x34 operation → result 0x03A8, single done, no extra operation.
- Back-to-back: start held high with operands changed in the DONE cycle to 0x10·0x10 → first product, then 0x0100 five cycles later.
- Abort in S2 → IDLE next cycle; no done; product keeps its prior value. A following start completes normally.
- Reset mid-operation: rst_n low in S1 → all outputs 0 immediately (asynchronous). After release with start held low, stays IDLE.
